// File: rtl/int_mult_pkg.sv
// Shared types for the FFT/NTT multiplier-pool arbiter.
// Owner/state enums, the result tag bundle and the default pipeline depth.
package int_mult_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FFT,
    OWN_NTT
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FFT_OWN,
    ST_NTT_OWN
  } arb_state_e;

  typedef struct packed {
    logic fft;
    logic ntt;
  } tag_t;

  // Depth of the 54x54 multiplier pipeline.
  localparam int MULT_LATENCY_DEF = 6;

endpackage

// File: rtl/int_mult_tag_pipe.sv
// Owner tag delay line matching the multiplier pipeline depth.
// Ports: clk, rst, din (tag in), dout (tag at pool output), pending (any tag in flight).
module int_mult_tag_pipe
  import int_mult_pkg::*;
#(
  parameter int DEPTH = MULT_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t din,
  output tag_t dout,
  output logic pending
);

  tag_t [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout    = pipe_q[DEPTH-1];
  assign pending = |pipe_q;

endmodule

// File: rtl/int_mult_arbiter.sv
// Grants the shared multiplier pool to FFT or NTT and tags issued ops by owner.
// Ports: req/issue per engine in; gnt, mux select, res_valid, hold_expired, busy, proto_err out.
module int_mult_arbiter
  import int_mult_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int MAX_HOLD     = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic fft_req,
  input  logic ntt_req,
  input  logic fft_issue,
  input  logic ntt_issue,
  output logic fft_gnt,
  output logic ntt_gnt,
  output logic grant_to_fft,
  output logic fft_res_valid,
  output logic ntt_res_valid,
  output logic hold_expired,
  output logic busy,
  output logic proto_err
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  arb_state_e      state_q, state_d;
  owner_e          ptr_q;
  logic [HW-1:0]   hold_q;
  logic            gtf_q;
  logic            err_q;
  logic            fft_gnt_q, ntt_gnt_q;
  tag_t            acc, res_tag;
  logic            pending;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fft_req && ntt_req)
          state_d = (ptr_q == OWN_NTT) ? ST_NTT_OWN : ST_FFT_OWN;
        else if (fft_req)
          state_d = ST_FFT_OWN;
        else if (ntt_req)
          state_d = ST_NTT_OWN;
      end
      ST_FFT_OWN:
        if (!fft_req) state_d = ntt_req ? ST_NTT_OWN : ST_IDLE;
      ST_NTT_OWN:
        if (!ntt_req) state_d = fft_req ? ST_FFT_OWN : ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= OWN_FFT;
      hold_q    <= '0;
      gtf_q     <= 1'b0;
      err_q     <= 1'b0;
      fft_gnt_q <= 1'b0;
      ntt_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fft_gnt_q <= (state_d == ST_FFT_OWN);
      ntt_gnt_q <= (state_d == ST_NTT_OWN);
      if (state_d != state_q)
        hold_q <= '0;
      else if (state_q != ST_IDLE && hold_q != HOLD_MAX)
        hold_q <= hold_q + 1'b1;
      // Round-robin: a release hands priority to the other engine.
      if (state_q == ST_FFT_OWN && state_d != ST_FFT_OWN)
        ptr_q <= OWN_NTT;
      else if (state_q == ST_NTT_OWN && state_d != ST_NTT_OWN)
        ptr_q <= OWN_FFT;
      // Idle keeps the last select so the pool mux stays quiet.
      if (state_d == ST_FFT_OWN)
        gtf_q <= 1'b1;
      else if (state_d == ST_NTT_OWN)
        gtf_q <= 1'b0;
      if ((fft_issue && !fft_gnt_q) || (ntt_issue && !ntt_gnt_q))
        err_q <= 1'b1;
    end
  end

  assign acc.fft = fft_issue & fft_gnt_q;
  assign acc.ntt = ntt_issue & ntt_gnt_q;

  int_mult_tag_pipe #(
    .DEPTH(MULT_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .din    (acc),
    .dout   (res_tag),
    .pending(pending)
  );

  assign fft_gnt       = fft_gnt_q;
  assign ntt_gnt       = ntt_gnt_q;
  assign grant_to_fft  = gtf_q;
  assign fft_res_valid = res_tag.fft;
  assign ntt_res_valid = res_tag.ntt;
  assign proto_err     = err_q;
  assign busy          = (state_q != ST_IDLE) | pending;
  assign hold_expired  = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) &&
                         ((state_q == ST_FFT_OWN && ntt_req) ||
                          (state_q == ST_NTT_OWN && fft_req));

endmodule

// File: tb/tb_int_mult_arbiter.sv
// Self-checking bench for int_mult_arbiter: vector table, corner sequences,
// and randomized traffic against a schedule-based reference model.
module tb_int_mult_arbiter;

  localparam int L  = 6;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fft_req = 0, ntt_req = 0, fft_issue = 0, ntt_issue = 0;
  logic fft_gnt, ntt_gnt, grant_to_fft, fft_res_valid, ntt_res_valid;
  logic hold_expired, busy, proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  int_mult_arbiter #(.MULT_LATENCY(L), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .fft_req(fft_req), .ntt_req(ntt_req),
    .fft_issue(fft_issue), .ntt_issue(ntt_issue),
    .fft_gnt(fft_gnt), .ntt_gnt(ntt_gnt),
    .grant_to_fft(grant_to_fft),
    .fft_res_valid(fft_res_valid), .ntt_res_valid(ntt_res_valid),
    .hold_expired(hold_expired), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  logic [7:0] ov;
  assign ov = {fft_gnt, ntt_gnt, grant_to_fft, fft_res_valid,
               ntt_res_valid, hold_expired, busy, proto_err};

  // Reference model: owner, priority, owned-cycle count, due-cycle queues.
  int cyc = 0;
  int m_own = 0;        // 0 none, 1 fft, 2 ntt
  bit m_ptr_ntt = 0;
  int m_held = 0;
  bit m_gtf = 0;
  bit m_err = 0;
  int fq[$];
  int nq[$];
  int nxt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = 0; m_ptr_ntt = 0; m_held = 0;
      m_gtf = 0; m_err = 0;
      fq.delete(); nq.delete();
    end else begin
      if (fft_issue) begin
        if (m_own == 1) fq.push_back(cyc + L);
        else m_err = 1;
      end
      if (ntt_issue) begin
        if (m_own == 2) nq.push_back(cyc + L);
        else m_err = 1;
      end
      nxt = m_own;
      if (m_own == 0) begin
        if (fft_req && ntt_req) nxt = m_ptr_ntt ? 2 : 1;
        else if (fft_req) nxt = 1;
        else if (ntt_req) nxt = 2;
      end else if (m_own == 1 && !fft_req) begin
        nxt = ntt_req ? 2 : 0;
      end else if (m_own == 2 && !ntt_req) begin
        nxt = fft_req ? 1 : 0;
      end
      if (m_own != 0 && nxt != m_own) m_ptr_ntt = (m_own == 1);
      if (nxt != 0 && nxt == m_own)
        m_held = (m_held < MH) ? m_held + 1 : MH;
      else
        m_held = 0;
      if (nxt == 1) m_gtf = 1;
      else if (nxt == 2) m_gtf = 0;
      m_own = nxt;
      cyc++;
    end
  end

  logic [7:0] mexp;
  logic m_he, m_frv, m_nrv, m_busy;

  always @(negedge clk) begin
    if (!rst) begin
      while (fq.size() > 0 && fq[0] < cyc) void'(fq.pop_front());
      while (nq.size() > 0 && nq[0] < cyc) void'(nq.pop_front());
      m_frv  = (fq.size() > 0 && fq[0] == cyc);
      m_nrv  = (nq.size() > 0 && nq[0] == cyc);
      m_busy = (m_own != 0) || fq.size() > 0 || nq.size() > 0;
      m_he   = (m_own != 0) && (m_held == MH) &&
               (m_own == 1 ? ntt_req : fft_req);
      mexp = {m_own == 1, m_own == 2, m_gtf, m_frv, m_nrv,
              m_he, m_busy, m_err};
      n_cmp++;
      if (ov !== mexp) begin
        n_bad++;
        $display("FAIL model cyc=%0d got=%b want=%b", cyc, ov, mexp);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] v);
    @(posedge clk);
    #1 {fft_req, ntt_req, fft_issue, ntt_issue} = v;
    @(negedge clk);
  endtask

  task automatic do_reset;
    {fft_req, ntt_req, fft_issue, ntt_issue} = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0] in;   // fft_req ntt_req fft_issue ntt_issue
    logic [7:0] exp;  // fg ng gtf frv nrv he busy err
  } vec_t;

  vec_t tbl[17];
  int f_left, n_left;

  initial begin
    // Solo FFT burst: req cycles 0-9, issue 2-9.
    tbl[0] = '{4'b1000, 8'b00000000};
    tbl[1] = '{4'b1000, 8'b10100010};
    for (int i = 2; i <= 7; i++) tbl[i] = '{4'b1010, 8'b10100010};
    for (int i = 8; i <= 9; i++) tbl[i] = '{4'b1010, 8'b10110010};
    tbl[10] = '{4'b0000, 8'b10110010};
    for (int i = 11; i <= 15; i++) tbl[i] = '{4'b0000, 8'b00110010};
    tbl[16] = '{4'b0000, 8'b00100000};

    repeat (2) @(posedge clk);
    do_reset();
    chk("reset_state", ov, 8'b0);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].in);
      chk($sformatf("solo_row%0d", i), ov, tbl[i].exp);
    end

    // Tie from reset, then handover with results in flight.
    do_reset();
    step(4'b1100);
    step(4'b1100);
    chk("tie_fft_first", {fft_gnt, ntt_gnt}, 8'b10);
    step(4'b1100);
    step(4'b0110);                 // FFT last owned cycle, issues
    chk("fft_last_own", {fft_gnt, ntt_gnt}, 8'b10);
    step(4'b0101);                 // NTT owns, issues
    chk("ntt_handover", {fft_gnt, ntt_gnt, grant_to_fft}, 8'b010);
    step(4'b0000);
    for (int k = 6; k <= 11; k++) begin
      step(4'b0000);
      chk($sformatf("handover_rv_c%0d", k),
          {fft_res_valid, ntt_res_valid},
          {6'b0, k == 9, k == 10});
    end

    // Lone FFT release flips priority: next tie goes to NTT.
    step(4'b1000);
    step(4'b1000);
    step(4'b0000);
    step(4'b1100);
    step(4'b1100);
    chk("tie_ntt_second", {fft_gnt, ntt_gnt, grant_to_fft}, 8'b010);

    // Fairness: FFT owns 10 cycles while NTT waits.
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      step({k <= 9, k >= 1, 2'b00});
      if (k >= 1 && k <= 10)
        chk($sformatf("fair_c%0d", k), {fft_gnt, hold_expired},
            {6'b0, 1'b1, k >= 5});
    end
    chk("fair_release", {fft_gnt, ntt_gnt, hold_expired}, 8'b010);

    // Protocol error: NTT issues while FFT owns.
    do_reset();
    step(4'b1000);
    step(4'b1000);
    step(4'b1001);
    chk("perr_before", proto_err, 8'd0);
    step(4'b1000);
    chk("perr_set", proto_err, 8'd1);
    for (int k = 0; k < 8; k++) begin
      step(4'b0000);
      chk("perr_no_ntt_rv", ntt_res_valid, 8'd0);
    end
    chk("perr_sticky", proto_err, 8'd1);
    do_reset();
    chk("perr_cleared", proto_err, 8'd0);

    // Async reset mid-burst with three ops in flight.
    step(4'b1000);
    step(4'b1010);
    step(4'b1010);
    step(4'b1010);
    #1 {fft_req, ntt_req, fft_issue, ntt_issue} = '0;
    rst = 1'b1;
    #1 chk("async_rst_outputs", ov, 8'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(4'b0000);
      chk("post_rst_quiet", {fft_res_valid, ntt_res_valid, busy}, 8'b0);
    end

    // Randomized traffic against the model.
    f_left = 0;
    n_left = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      if (f_left > 0) f_left--;
      else if ($urandom_range(3) == 0) f_left = $urandom_range(12, 1);
      if (n_left > 0) n_left--;
      else if ($urandom_range(3) == 0) n_left = $urandom_range(12, 1);
      fft_req   = (f_left > 0);
      ntt_req   = (n_left > 0);
      fft_issue = (m_own == 1 && $urandom_range(1) == 1) ||
                  ($urandom_range(49) == 0);
      ntt_issue = (m_own == 2 && $urandom_range(1) == 1) ||
                  ($urandom_range(49) == 0);
      if ($urandom_range(299) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_mult_arbiter.md
# int_mult_arbiter

Arbiter and sequencer for the shared four-lane 54x54 integer multiplier pool used by the FFT and NTT engines. It grants the pool to one engine at a time and drives the pool's `grant_to_fft` select. It tags every issued operation with its owner and produces per-engine result-valid strobes aligned with the multiplier pipeline output, so either engine can take ownership while the other's results are still in flight. It sits between the two engine controllers and the multiplier pool.

## Interface
Parameters:
- `MULT_LATENCY`, default 6: cycles from pool input to `result`/`result_low` valid; must be ≥1.
- `MAX_HOLD`, default 256: owner burst cycles after which a waiting peer gains priority; 0 disables fairness.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous reset, active-high.
- `fft_req`  in  1  FFT wants the pool; held for the whole burst.
- `ntt_req`  in  1  NTT wants the pool; held for the whole burst.
- `fft_issue`  in  1  FFT presents a valid 4-lane operation this cycle.
- `ntt_issue`  in  1  NTT presents a valid 4-lane operation this cycle.
- `fft_gnt`  out  1  FFT owns the pool.
- `ntt_gnt`  out  1  NTT owns the pool.
- `grant_to_fft`  out  1  pool input mux select.
- `fft_res_valid`  out  1  pool result belongs to FFT this cycle.
- `ntt_res_valid`  out  1  pool result belongs to NTT this cycle.
- `hold_expired`  out  1  current owner has exceeded `MAX_HOLD` while the peer waits.
- `busy`  out  1  a grant is active or a result is in flight.
- `proto_err`  out  1  sticky; an issue arrived without a grant.

## Operation
- States: `IDLE`, `FFT_OWN`, `NTT_OWN`. All grant outputs are registered and decoded from the state.
- **IDLE:**
  - Exactly one request → go to that owner.
  - Both requests → priority pointer decides. The pointer resets to FFT and flips to the non-owner on every release, giving round-robin.
- **FFT_OWN/NTT_OWN:**
  - While the owner's req is high, stay.
  - When the owner's req drops: if the peer is requesting, go directly to peer-own (no idle cycle); otherwise go to `IDLE`.
- **Fairness:**
  - Hold counter is cleared on entry to an own state and increments each owned cycle. It saturates at `MAX_HOLD`.
  - `hold_expired` = counter == `MAX_HOLD` and peer req is high. It is advisory only; the owner must release. There is no preemption.
- **`grant_to_fft`:** 1 in `FFT_OWN`, 0 in `NTT_OWN`. In `IDLE` it holds its last value, so the mux does not toggle needlessly.
- **Tagging:**
  - An accepted issue is one where `x_issue` and `x_gnt` are both high.
  - Each cycle, push {fft_acc, ntt_acc} into a `MULT_LATENCY`-deep shift register. The output stage drives `fft_res_valid` and `ntt_res_valid`.
  - The two tag bits are never both set.
- **Protocol errors:**
  - An issue without a grant is not tagged and sets `proto_err`.
  - `proto_err` clears only on `rst`.
- **`busy`:** state ≠ `IDLE` or any tag bit set in the pipe.

## Timing
- **Reset values:** state `IDLE`; pointer FFT; `fft_gnt`, `ntt_gnt` = 0; `grant_to_fft` = 0; both res_valid = 0; `hold_expired` = 0; `busy` = 0; `proto_err` = 0; tag pipe cleared.
- **Grant latency:** req high at edge t in `IDLE` → gnt high after edge t+1.
- **Release:** req low at t → gnt low after t+1. In the same cycle the peer's gnt goes high if the peer is requesting.
- **Result latency:** accepted issue at cycle c → `x_res_valid` high at cycle c+`MULT_LATENCY`, for exactly one cycle per issue. Back-to-back issues give back-to-back valids.
- **Ownership change:** tags already in flight keep their original owner, so valids for both engines may appear in adjacent cycles after a handover.
- **Simultaneous requests in IDLE:** arbitration is decided in the same cycle per the pointer.
- **Reset mid-burst:** grants drop asynchronously and the tag pipe is flushed. Results already in the multipliers are discarded and no valid is emitted for them.

## Structure
- Shared package `int_mult_pkg`:
  - `owner_e` enum {OWN_NONE, OWN_FFT, OWN_NTT}.
  - Arbiter state enum.
  - Default `MULT_LATENCY` constant, kept equal to the 54x54 multiplier pipeline depth.
- One sub-module, `int_mult_tag_pipe`: a parameterised depth, 2-bit-wide shift register with async reset.
- The arbiter FSM, hold counter and error flag live in the top module.

## Test plan
- **Solo FFT burst:** `fft_req` for 10 cycles, issuing on cycles 2–9 → `fft_gnt` at cycle 1, `grant_to_fft`=1, `fft_res_valid` on cycles 8–15, `ntt_res_valid` never.
- **Simultaneous requests from reset:** → FFT granted first. On FFT release NTT is granted the next cycle with `grant_to_fft`=0. A second tie after both release → NTT first.
- **Handover with results in flight:** FFT issues on its last owned cycle c; NTT issues at c+1 → `fft_res_valid` at c+6, `ntt_res_valid` at c+7.
- **Fairness:** `MAX_HOLD`=4, FFT holds 10 cycles, NTT requests throughout → `hold_expired` high from the 5th owned cycle until release; grant is not forcibly revoked.
- **Protocol error:** `ntt_issue` pulsed while FFT owns → no `ntt_res_valid`, `proto_err`=1, and it remains set until `rst`.
- **Async reset mid-burst:** `rst` pulsed between clock edges with 3 ops in flight → all outputs 0 immediately and no res_valid afterward.
